counter_scan_sequencer: RTL and testbench

//  Sequences one saturating COUNTER instance through a programmed scan of up to NSEG segments.

---
 rtl/counter_scan_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_counter_scan_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_scan_sequencer.sv
// Drives one saturating counter through a table of up to NSEG {max, increment} segments.
// Optional SCAN_DWELL_EN adds a per-segment dwell (counter held at max) between segments.
module counter_scan_sequencer #(
    parameter int RESOLUTION = 64,
    parameter int NSEG       = 8,
    parameter int SEG_AW     = 3,
    parameter int DWELL_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [SEG_AW-1:0]     cfg_addr,
    input  logic [RESOLUTION-1:0] cfg_max,
    input  logic [RESOLUTION-1:0] cfg_inc,
    input  logic [DWELL_W-1:0]    cfg_dwell,
    input  logic [SEG_AW:0]       seg_count,
    input  logic                  loop_en,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  ctr_overflow,
    output logic [RESOLUTION-1:0] ctr_max,
    output logic [RESOLUTION-1:0] ctr_inc,
    output logic                  ctr_reset,
    output logic [SEG_AW-1:0]     seg_index,
    output logic                  busy,
    output logic                  seg_done,
    output logic                  scan_done,
    output logic [2:0]            state_dbg
);

    // Handshake: none; start/abort/cfg_we are level strobes sampled on each rising edge,
    // and seg_done/scan_done are single-cycle registered pulses.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3
`ifdef SCAN_DWELL_EN
        , S_DWELL = 3'd4
`endif
    } state_t;

    localparam logic [SEG_AW:0]   CNT_ONE = 1;
    localparam logic [SEG_AW-1:0] IDX_ONE = 1;

    state_t                  state, state_n;
    logic [SEG_AW-1:0]       seg_index_n;
    logic [SEG_AW:0]         seg_cnt_q, seg_cnt_n;
    logic [RESOLUTION-1:0]   ctr_max_n, ctr_inc_n;
    logic                    seg_done_n, scan_done_n;
    logic                    last_seg;
    logic [SEG_AW-1:0]       next_idx;

    logic [RESOLUTION-1:0]   tbl_max [NSEG];
    logic [RESOLUTION-1:0]   tbl_inc [NSEG];

`ifdef SCAN_DWELL_EN
    localparam logic [DWELL_W-1:0] DW_ONE = 1;
    logic [DWELL_W-1:0]      tbl_dwell [NSEG];
    logic [DWELL_W-1:0]      dwell_cnt, dwell_cnt_n;
`else
    logic                    unused_dwell;
    assign unused_dwell = ^cfg_dwell;
`endif

    assign state_dbg = state;

    // The table is only writable while idle so a running scan sees stable entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NSEG; i++) begin
                tbl_max[i] <= '0;
                tbl_inc[i] <= '0;
`ifdef SCAN_DWELL_EN
                tbl_dwell[i] <= '0;
`endif
            end
        end else if (cfg_we && state == S_IDLE) begin
            tbl_max[cfg_addr] <= cfg_max;
            tbl_inc[cfg_addr] <= cfg_inc;
`ifdef SCAN_DWELL_EN
            tbl_dwell[cfg_addr] <= cfg_dwell;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        seg_index_n = seg_index;
        seg_cnt_n   = seg_cnt_q;
        ctr_max_n   = ctr_max;
        ctr_inc_n   = ctr_inc;
        seg_done_n  = 1'b0;
        scan_done_n = 1'b0;
`ifdef SCAN_DWELL_EN
        dwell_cnt_n = dwell_cnt;
`endif
        last_seg = ({1'b0, seg_index} == (seg_cnt_q - CNT_ONE));
        next_idx = last_seg ? '0 : (seg_index + IDX_ONE);

        if (abort) begin
            state_n     = S_IDLE;
            seg_index_n = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        seg_cnt_n   = seg_count;
                        seg_index_n = '0;
                        state_n     = (seg_count == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    ctr_max_n = tbl_max[seg_index];
                    ctr_inc_n = tbl_inc[seg_index];
                    state_n   = S_RUN;
                end
                S_RUN: begin
                    if (ctr_overflow) begin
                        seg_done_n = 1'b1;
                        if (last_seg && !loop_en) begin
                            state_n = S_DONE;
                        end else begin
                            seg_index_n = next_idx;
`ifdef SCAN_DWELL_EN
                            if (tbl_dwell[seg_index] != '0) begin
                                dwell_cnt_n = tbl_dwell[seg_index];
                                state_n     = S_DWELL;
                            end else begin
                                state_n = S_LOAD;
                            end
`else
                            state_n = S_LOAD;
`endif
                        end
                    end
                end
`ifdef SCAN_DWELL_EN
                S_DWELL: begin
                    if (dwell_cnt <= DW_ONE) begin
                        state_n = S_LOAD;
                    end else begin
                        dwell_cnt_n = dwell_cnt - DW_ONE;
                    end
                end
`endif
                S_DONE: begin
                    scan_done_n = 1'b1;
                    state_n     = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // busy and ctr_reset are registered from the next state so they track the state itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            seg_index <= '0;
            seg_cnt_q <= '0;
            ctr_max   <= '0;
            ctr_inc   <= '0;
            ctr_reset <= 1'b1;
            busy      <= 1'b0;
            seg_done  <= 1'b0;
            scan_done <= 1'b0;
`ifdef SCAN_DWELL_EN
            dwell_cnt <= '0;
`endif
        end else begin
            state     <= state_n;
            seg_index <= seg_index_n;
            seg_cnt_q <= seg_cnt_n;
            ctr_max   <= ctr_max_n;
            ctr_inc   <= ctr_inc_n;
            ctr_reset <= (state_n == S_IDLE) || (state_n == S_LOAD) || (state_n == S_DONE);
            busy      <= (state_n != S_IDLE);
            seg_done  <= seg_done_n;
            scan_done <= scan_done_n;
`ifdef SCAN_DWELL_EN
            dwell_cnt <= dwell_cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_counter_scan_sequencer.sv
// Directed bench for counter_scan_sequencer: a cycle table for a basic two-segment scan plus
// hand sequences (zero-max segment, looping, abort, locked table, empty scan, dwell with SCAN_DWELL_EN).
module tb_counter_scan_sequencer;

    localparam int RES = 64;
    localparam int AW  = 3;
    localparam int DW  = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_DWELL = 3'd4;

    logic           clk;
    logic           reset;
    logic           cfg_we;
    logic [AW-1:0]  cfg_addr;
    logic [RES-1:0] cfg_max;
    logic [RES-1:0] cfg_inc;
    logic [DW-1:0]  cfg_dwell;
    logic [AW:0]    seg_count;
    logic           loop_en;
    logic           start;
    logic           abort;
    logic           ctr_overflow;
    logic [RES-1:0] ctr_max;
    logic [RES-1:0] ctr_inc;
    logic           ctr_reset;
    logic [AW-1:0]  seg_index;
    logic           busy;
    logic           seg_done;
    logic           scan_done;
    logic [2:0]     state_dbg;

    logic           use_model;
    logic           ovf_drv;
    logic [RES-1:0] mdl_cnt;

    int n_cmp;
    int n_err;

    counter_scan_sequencer #(.RESOLUTION(RES), .NSEG(8), .SEG_AW(AW), .DWELL_W(DW)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_max(cfg_max),
        .cfg_inc(cfg_inc), .cfg_dwell(cfg_dwell), .seg_count(seg_count), .loop_en(loop_en),
        .start(start), .abort(abort), .ctr_overflow(ctr_overflow), .ctr_max(ctr_max),
        .ctr_inc(ctr_inc), .ctr_reset(ctr_reset), .seg_index(seg_index), .busy(busy),
        .seg_done(seg_done), .scan_done(scan_done), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Saturating counter model standing in for the real counter instance.
    always @(posedge clk or negedge reset) begin
        if (!reset)                          mdl_cnt <= '0;
        else if (ctr_reset)                  mdl_cnt <= '0;
        else if (mdl_cnt + ctr_inc >= ctr_max) mdl_cnt <= ctr_max;
        else                                 mdl_cnt <= mdl_cnt + ctr_inc;
    end
    assign ctr_overflow = use_model ? (mdl_cnt == ctr_max) : ovf_drv;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [RES-1:0] act, input logic [RES-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cfg_write(input int a, input int mx, input int inc, input int dwl);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(a);
        cfg_max   = RES'(mx);
        cfg_inc   = RES'(inc);
        cfg_dwell = DW'(dwl);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic check_state(input string name, input logic [2:0] st);
        check(name, RES'(state_dbg), RES'(st));
    endtask

    typedef struct {
        logic           start;
        logic           ovf;
        logic [2:0]     st;
        logic           busy;
        logic           crst;
        logic [AW-1:0]  idx;
        logic           sdone;
        logic           scdone;
        logic [RES-1:0] max;
        logic [RES-1:0] inc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_max = '0; cfg_inc = '0; cfg_dwell = '0;
        seg_count = '0; loop_en = 1'b0; start = 1'b0; abort = 1'b0;
        use_model = 1'b0; ovf_drv = 1'b0;

        // test 1 cycle table: {start, ovf, state, busy, ctr_reset, idx, seg_done, scan_done, max, inc}
        vecs[0] = '{1'b1, 1'b0, ST_LOAD, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 64'd0,  64'd0};
        vecs[1] = '{1'b0, 1'b0, ST_RUN,  1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 64'd10, 64'd3};
        vecs[2] = '{1'b0, 1'b0, ST_RUN,  1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 64'd10, 64'd3};
        vecs[3] = '{1'b0, 1'b1, ST_LOAD, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 64'd10, 64'd3};
        vecs[4] = '{1'b0, 1'b1, ST_RUN,  1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 64'd4,  64'd1};
        vecs[5] = '{1'b0, 1'b1, ST_DONE, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 64'd4,  64'd1};
        vecs[6] = '{1'b0, 1'b0, ST_IDLE, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 64'd4,  64'd1};
        vecs[7] = '{1'b0, 1'b0, ST_IDLE, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 64'd4,  64'd1};

        #23;
        check("rst_ctr_reset", RES'(ctr_reset), 1);
        check("rst_busy", RES'(busy), 0);
        check("rst_ctr_max", ctr_max, 0);
        check_state("rst_state", ST_IDLE);
        reset = 1'b1;
        tick();

        // test 1: two-segment scan, overflow driven directly
        cfg_write(0, 10, 3, 0);
        cfg_write(1, 4, 1, 0);
        seg_count = 4'd2;
        for (int i = 0; i < 8; i++) begin
            start   = vecs[i].start;
            ovf_drv = vecs[i].ovf;
            tick();
            check($sformatf("t1_state[%0d]", i), RES'(state_dbg), RES'(vecs[i].st));
            check($sformatf("t1_busy[%0d]", i), RES'(busy), RES'(vecs[i].busy));
            check($sformatf("t1_crst[%0d]", i), RES'(ctr_reset), RES'(vecs[i].crst));
            check($sformatf("t1_idx[%0d]", i), RES'(seg_index), RES'(vecs[i].idx));
            check($sformatf("t1_sdone[%0d]", i), RES'(seg_done), RES'(vecs[i].sdone));
            check($sformatf("t1_scdone[%0d]", i), RES'(scan_done), RES'(vecs[i].scdone));
            check($sformatf("t1_max[%0d]", i), ctr_max, vecs[i].max);
            check($sformatf("t1_inc[%0d]", i), ctr_inc, vecs[i].inc);
        end
        start = 1'b0; ovf_drv = 1'b0;

        // test 2: zero-max segment completes in its first RUN cycle
        cfg_write(0, 0, 5, 0);
        cfg_write(1, 7, 2, 0);
        use_model = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check_state("t2_run0", ST_RUN);
        check("t2_sdone_early", RES'(seg_done), 0);
        tick();
        check("t2_sdone0", RES'(seg_done), 1);
        check_state("t2_load1", ST_LOAD);
        check("t2_idx1", RES'(seg_index), 1);
        tick();
        check_state("t2_run1", ST_RUN);
        check("t2_max1", ctr_max, 7);
        check("t2_inc1", ctr_inc, 2);
        for (int i = 0; i < 4; i++) tick();
        check("t2_sdone_mid", RES'(seg_done), 0);
        check_state("t2_still_run", ST_RUN);
        tick();
        check("t2_sdone1", RES'(seg_done), 1);
        check_state("t2_done", ST_DONE);
        tick();
        check("t2_scan_done", RES'(scan_done), 1);
        check("t2_busy_low", RES'(busy), 0);

        // test 3: loop on a single segment, then clear loop_en
        seg_count = 4'd1; loop_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        tick();
        check_state("t3_reload_a", ST_LOAD);
        check("t3_sdone_a", RES'(seg_done), 1);
        check("t3_idx_a", RES'(seg_index), 0);
        tick();
        tick();
        check_state("t3_reload_b", ST_LOAD);
        check("t3_scdone_b", RES'(scan_done), 0);
        loop_en = 1'b0;
        tick();
        check_state("t3_run_c", ST_RUN);
        tick();
        check_state("t3_done", ST_DONE);
        check("t3_sdone_c", RES'(seg_done), 1);
        tick();
        check("t3_scan_done", RES'(scan_done), 1);
        check_state("t3_idle", ST_IDLE);
        tick();
        check("t3_scan_done_once", RES'(scan_done), 0);

        // test 4: abort mid-RUN of seg1; start+abort in IDLE
        use_model = 1'b0; ovf_drv = 1'b0; seg_count = 4'd2;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        ovf_drv = 1'b1; tick(); ovf_drv = 1'b0;
        tick();
        check_state("t4_run_seg1", ST_RUN);
        check("t4_idx_seg1", RES'(seg_index), 1);
        abort = 1'b1; tick(); abort = 1'b0;
        check_state("t4_abort_idle", ST_IDLE);
        check("t4_abort_crst", RES'(ctr_reset), 1);
        check("t4_abort_idx", RES'(seg_index), 0);
        check("t4_abort_busy", RES'(busy), 0);
        tick();
        check("t4_no_scan_done", RES'(scan_done), 0);
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        check_state("t4_start_abort", ST_IDLE);
        check("t4_start_abort_busy", RES'(busy), 0);
        tick();
        check_state("t4_still_idle", ST_IDLE);

        // test 5: table write ignored while busy; empty scan
        cfg_write(0, 20, 4, 0);
        seg_count = 4'd1;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check("t5_max_a", ctr_max, 20);
        cfg_we = 1'b1; cfg_addr = '0; cfg_max = 64'd99; cfg_inc = 64'd9;
        tick();
        cfg_we = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check("t5_max_locked", ctr_max, 20);
        check("t5_inc_locked", ctr_inc, 4);
        abort = 1'b1; tick(); abort = 1'b0;
        seg_count = 4'd0;
        start = 1'b1; tick(); start = 1'b0;
        check_state("t5_empty_done", ST_DONE);
        check("t5_empty_scdone0", RES'(scan_done), 0);
        tick();
        check("t5_empty_scdone1", RES'(scan_done), 1);
        check_state("t5_empty_idle", ST_IDLE);
        check("t5_empty_no_seg", RES'(seg_done), 0);

`ifdef SCAN_DWELL_EN
        // test 6: dwell of 5 cycles after seg0, then async reset mid-dwell
        begin
            int dwell_cycles;
            cfg_write(0, 0, 1, 5);
            cfg_write(1, 3, 1, 0);
            use_model = 1'b1; seg_count = 4'd2;
            start = 1'b1; tick(); start = 1'b0;
            tick();
            tick();
            check("t6_sdone", RES'(seg_done), 1);
            dwell_cycles = 0;
            for (int i = 0; i < 8 && state_dbg == ST_DWELL; i++) begin
                check("t6_dwell_crst", RES'(ctr_reset), 0);
                dwell_cycles++;
                tick();
            end
            check("t6_dwell_cycles", RES'(dwell_cycles), 5);
            check_state("t6_load_after", ST_LOAD);
            check("t6_idx", RES'(seg_index), 1);
            abort = 1'b1; tick(); abort = 1'b0;
            start = 1'b1; tick(); start = 1'b0;
            tick(); tick(); tick();
            check_state("t6_in_dwell", ST_DWELL);
            #2 reset = 1'b0;
            #1;
            check("t6_areset_crst", RES'(ctr_reset), 1);
            check("t6_areset_busy", RES'(busy), 0);
            check("t6_areset_idx", RES'(seg_index), 0);
            check_state("t6_areset_state", ST_IDLE);
            #10 reset = 1'b1;
            tick();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
